// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message feeder.
package sha256_pkg;

   typedef enum logic [2:0] {
      StData,
      StPad80,
      StZero,
      StLenHi,
      StLenLo,
      StWaitCore
   } state_e;

   localparam int unsigned CHUNK_WORDS = 16;
   localparam logic [3:0]  LEN_HI_IDX  = 4'd14;
   localparam logic [3:0]  LEN_LO_IDX  = 4'd15;
   localparam logic [7:0]  PAD_BYTE    = 8'h80;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/sha256_msg_feeder_if.sv
// Upstream word stream plus the core word-load side of the feeder.
interface sha256_msg_feeder_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic [1:0]  s_bytes;
   logic        core_busy_i;
   logic        core_done_i;
   logic        dat_vaild_o;
   logic [31:0] dat_lsb_o;
   logic        chunk_busy_o;
   logic        msg_done_o;

   modport slave (
      input  s_valid, s_data, s_last, s_bytes, core_busy_i, core_done_i,
      output s_ready, dat_vaild_o, dat_lsb_o, chunk_busy_o, msg_done_o
   );

   modport master (
      output s_valid, s_data, s_last, s_bytes, core_busy_i, core_done_i,
      input  s_ready, dat_vaild_o, dat_lsb_o, chunk_busy_o, msg_done_o
   );
endinterface

// File: rtl/sha256_pad_word.sv
// Final partial word: keep the first n bytes, put 0x80 in byte n, clear the rest.
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [1:0]  n_i,
   output logic [31:0] word_o
);

   always_comb begin
      word_o = data_i;
      // n_i == 0 means four valid bytes, so the word passes through untouched
      for (int b = 1; b < 4; b++) begin
         if (n_i != 2'd0) begin
            if (b == int'(n_i)) begin
               word_o[8*b +: 8] = PAD_BYTE;
            end else if (b > int'(n_i)) begin
               word_o[8*b +: 8] = 8'h00;
            end
         end
      end
   end

endmodule

// File: rtl/sha256_msg_feeder.sv
// Feeds a padded message to the SHA-256 core in 16-word chunks, one chunk per core_done.
module sha256_msg_feeder
   import sha256_pkg::*;
#(
   parameter int unsigned LEN_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   sha256_msg_feeder_if.slave  bus
);

   localparam int unsigned IdxW = $clog2(CHUNK_WORDS);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   w_idx_q, w_idx_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              last_seen_q, last_seen_d;
   logic              pad80_owed_q, pad80_owed_d;
   logic              len_pending_q, len_pending_d;
   logic              chunk_busy_q, chunk_busy_d;
   logic              dat_vaild_q, dat_vaild_d;
   logic [31:0]       dat_lsb_q, dat_lsb_d;

   logic              xfer;
   logic              emit;
   logic              pad_hit;
   logic [31:0]       pad_word;
   logic [6:0]        len_inc;
   logic [63:0]       len64;
   logic [63:0]       len_sum;

   sha256_pad_word u_pad_word (
      .data_i (bus.s_data),
      .n_i    (bus.s_bytes),
      .word_o (pad_word)
   );

   assign len64   = 64'(len_q);
   assign len_inc = (bus.s_last && bus.s_bytes != 2'd0) ? {2'b00, bus.s_bytes, 3'b000} : 7'd32;
   assign len_sum = len64 + 64'(len_inc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StData;
         w_idx_q       <= '0;
         len_q         <= '0;
         last_seen_q   <= 1'b0;
         pad80_owed_q  <= 1'b0;
         len_pending_q <= 1'b0;
         chunk_busy_q  <= 1'b0;
         dat_vaild_q   <= 1'b0;
         dat_lsb_q     <= '0;
      end else begin
         state_q       <= state_d;
         w_idx_q       <= w_idx_d;
         len_q         <= len_d;
         last_seen_q   <= last_seen_d;
         pad80_owed_q  <= pad80_owed_d;
         len_pending_q <= len_pending_d;
         chunk_busy_q  <= chunk_busy_d;
         dat_vaild_q   <= dat_vaild_d;
         dat_lsb_q     <= dat_lsb_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      w_idx_d       = w_idx_q;
      len_d         = len_q;
      last_seen_d   = last_seen_q;
      pad80_owed_d  = pad80_owed_q;
      len_pending_d = len_pending_q;
      chunk_busy_d  = chunk_busy_q;
      dat_lsb_d     = '0;
      emit          = 1'b0;
      pad_hit       = 1'b0;
      xfer          = bus.s_valid && bus.s_ready;

      unique case (state_q)
         StData: begin
            if (xfer) begin
               emit         = 1'b1;
               len_d        = len_sum[LEN_W-1:0];
               chunk_busy_d = 1'b1;
               dat_lsb_d    = bus.s_data;
               if (bus.s_last) begin
                  last_seen_d = 1'b1;
                  if (bus.s_bytes == 2'd0) begin
                     if (w_idx_q == LEN_LO_IDX) pad80_owed_d = 1'b1;
                     else                       state_d      = StPad80;
                  end else begin
                     dat_lsb_d = pad_word;
                     pad_hit   = 1'b1;
                  end
               end
            end
         end
         StPad80: begin
            emit      = 1'b1;
            dat_lsb_d = {24'h0, PAD_BYTE};
            pad_hit   = 1'b1;
         end
         StZero: begin
            emit = 1'b1;
            if (w_idx_q == LEN_HI_IDX - 4'd1 && !len_pending_q) state_d = StLenHi;
         end
         StLenHi: begin
            emit      = 1'b1;
            dat_lsb_d = bswap32(len64[63:32]);
            state_d   = StLenLo;
         end
         StLenLo: begin
            emit      = 1'b1;
            dat_lsb_d = bswap32(len64[31:0]);
         end
         StWaitCore: begin
            if (bus.core_done_i) begin
               if (!last_seen_q) begin
                  state_d = StData;
               end else if (pad80_owed_q) begin
                  pad80_owed_d = 1'b0;
                  state_d      = StPad80;
               end else if (len_pending_q) begin
                  len_pending_d = 1'b0;
                  state_d       = StZero;
               end else begin
                  state_d      = StData;
                  len_d        = '0;
                  last_seen_d  = 1'b0;
                  chunk_busy_d = 1'b0;
               end
            end
         end
         default: state_d = StData;
      endcase

      // The 0x80 word landing in the length slots pushes the length into an extra chunk
      if (pad_hit) begin
         if (w_idx_q == LEN_HI_IDX - 4'd1) begin
            state_d = StLenHi;
         end else begin
            state_d = StZero;
            if (w_idx_q >= LEN_HI_IDX) len_pending_d = 1'b1;
         end
      end

      if (emit) begin
         if (w_idx_q == LEN_LO_IDX) begin
            w_idx_d = '0;
            state_d = StWaitCore;
         end else begin
            w_idx_d = w_idx_q + 4'd1;
         end
      end
      dat_vaild_d = emit;
   end

   always_comb begin
      bus.s_ready      = rst_n && (state_q == StData) && !bus.core_busy_i;
      bus.msg_done_o   = (state_q == StWaitCore) && bus.core_done_i && last_seen_q &&
                         !pad80_owed_q && !len_pending_q;
      bus.dat_vaild_o  = dat_vaild_q;
      bus.dat_lsb_o    = dat_lsb_q;
      bus.chunk_busy_o = chunk_busy_q;
   end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: byte-level padding model, emulated core, directed messages.
module tb_sha256_msg_feeder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   sha256_msg_feeder_if bus ();

   sha256_msg_feeder #(.LEN_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] msg_q[$];
   int          core_delay = 3;
   int          core_wcnt  = 0;
   bit          waiting    = 1'b0;
   logic        emu_done   = 1'b0;
   logic        spur_done  = 1'b0;
   logic        emu_busy   = 1'b0;
   int          done_cnt   = 0;
   int          word_no    = 0;

   assign bus.core_done_i = emu_done | spur_done;
   assign bus.core_busy_i = emu_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Padding model on a plain byte stream: message, 0x80, zeros to 56 mod 64, 64-bit BE length.
   task automatic model(input int last_n);
      byte unsigned bq[$];
      logic [63:0]  bitlen;
      logic [31:0]  w;
      int           nb;
      exp_q.delete();
      for (int i = 0; i < msg_q.size(); i++) begin
         w  = msg_q[i];
         nb = (i == msg_q.size() - 1) ? last_n : 4;
         for (int b = 0; b < nb; b++) bq.push_back(w[8*b +: 8]);
      end
      bitlen = 64'(bq.size()) * 64'd8;
      bq.push_back(8'h80);
      while (bq.size() % 64 != 56) bq.push_back(8'h00);
      for (int k = 7; k >= 0; k--) bq.push_back(bitlen[8*k +: 8]);
      for (int i = 0; i < bq.size(); i += 4) exp_q.push_back({bq[i+3], bq[i+2], bq[i+1], bq[i]});
   endtask

   task automatic fill_pattern(input int nwords, input int last_n);
      logic [31:0] w;
      msg_q.delete();
      for (int i = 0; i < nwords; i++) begin
         w = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
         if (i == nwords - 1) for (int b = last_n; b < 4; b++) w[8*b +: 8] = 8'hEE;
         msg_q.push_back(w);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] nb,
                            input bit gaps);
      int budget;
      int g;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      bus.s_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      bus.s_bytes = nb;
      budget      = 0;
      forever begin
         @(negedge clk);
         if (bus.s_ready) break;
         budget++;
         if (budget > 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL s_ready timeout: got 0, expected 1 within 500 cycles");
            break;
         end
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic wait_msg_done(input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 3000) begin @(posedge clk); t++; end
      #1;
      repeat (4) @(posedge clk);
      #1;
      check("msg_done pulses", 32'(done_cnt - d0), 32'd1);
      check("words left over", 32'(exp_q.size()), 32'd0);
      check("chunk_busy after msg", 32'(bus.chunk_busy_o), 32'd0);
   endtask

   task automatic run_msg(input int last_n, input bit gaps);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < msg_q.size(); i++)
         send_word(msg_q[i], i == msg_q.size() - 1, 2'(last_n % 4), gaps);
      wait_msg_done(d0);
   endtask

   task automatic load_abc();
      msg_q.delete();
      msg_q.push_back(32'h00636261);
      model(3);
      check("abc model size", 32'(exp_q.size()), 32'd16);
      check("abc model w0", exp_q[0], 32'h80636261);
      check("abc model w15", exp_q[15], 32'h18000000);
   endtask

   // Core emulation: counts words, then holds busy for core_delay cycles and pulses done.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            core_wcnt = 0;
         end else if (bus.dat_vaild_o) begin
            core_wcnt++;
            if (core_wcnt == 16) begin
               core_wcnt = 0;
               @(posedge clk); #1;
               emu_busy = 1'b1;
               waiting  = 1'b1;
               repeat (core_delay) @(posedge clk);
               #1 emu_done = 1'b1;
               @(posedge clk); #1;
               emu_done = 1'b0;
               emu_busy = 1'b0;
               waiting  = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (waiting) begin
            check("s_ready in WAIT_CORE", 32'(bus.s_ready), 32'd0);
            check("dat_vaild in WAIT_CORE", 32'(bus.dat_vaild_o), 32'd0);
         end
         if (bus.dat_vaild_o) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra word: got %h, expected no word", bus.dat_lsb_o);
            end else begin
               check($sformatf("word %0d", word_no), bus.dat_lsb_o, exp_q.pop_front());
            end
            word_no++;
         end
         if (bus.core_done_i) begin
            check("msg_done_o on core_done", 32'(bus.msg_done_o),
                  32'(waiting && exp_q.size() == 0));
         end else if (bus.msg_done_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL msg_done without core_done: got 1, expected 0");
         end
         if (bus.msg_done_o) done_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.s_bytes = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset dat_vaild", 32'(bus.dat_vaild_o), 32'd0);
      check("reset dat_lsb", bus.dat_lsb_o, 32'd0);
      check("reset chunk_busy", 32'(bus.chunk_busy_o), 32'd0);
      check("reset msg_done", 32'(bus.msg_done_o), 32'd0);
      check("reset s_ready", 32'(bus.s_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle s_ready", 32'(bus.s_ready), 32'd1);

      load_abc();
      run_msg(3, 1'b0);

      fill_pattern(14, 3);
      model(3);
      w = exp_q[13];
      check("55B model w13 byte3", 32'(w[31:24]), 32'h80);
      check("55B model w14", exp_q[14], 32'h00000000);
      check("55B model w15", exp_q[15], 32'hB8010000);
      run_msg(3, 1'b0);

      fill_pattern(14, 4);
      model(4);
      check("56B model size", 32'(exp_q.size()), 32'd32);
      check("56B model w14", exp_q[14], 32'h00000080);
      check("56B model w15", exp_q[15], 32'h00000000);
      check("56B model c2 w15", exp_q[31], 32'hC0010000);
      run_msg(4, 1'b0);

      fill_pattern(16, 4);
      model(4);
      check("64B model c2 w0", exp_q[16], 32'h00000080);
      check("64B model c2 w15", exp_q[31], 32'h00020000);
      run_msg(4, 1'b0);

      fill_pattern(16, 1);
      model(1);
      run_msg(1, 1'b0);

      fill_pattern(15, 4);
      model(4);
      run_msg(4, 1'b0);

      // A done pulse outside WAIT_CORE must be ignored
      spur_done = 1'b1;
      @(posedge clk); #1;
      spur_done = 1'b0;
      check("spurious done s_ready", 32'(bus.s_ready), 32'd1);

      core_delay = 70;
      fill_pattern(20, 2);
      model(2);
      run_msg(2, 1'b1);
      core_delay = 3;

      fill_pattern(10, 4);
      model(4);
      for (int i = 0; i < 7; i++) send_word(msg_q[i], 1'b0, 2'd0, 1'b0);
      check("pre-reset dat_vaild", 32'(bus.dat_vaild_o), 32'd1);
      check("pre-reset chunk_busy", 32'(bus.chunk_busy_o), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid reset dat_vaild", 32'(bus.dat_vaild_o), 32'd0);
      check("mid reset dat_lsb", bus.dat_lsb_o, 32'd0);
      check("mid reset chunk_busy", 32'(bus.chunk_busy_o), 32'd0);
      check("mid reset s_ready", 32'(bus.s_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      load_abc();
      run_msg(3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
